// File: rtl/field_pkg.sv
// Shared widths and FSM encoding for the field packer slice.
package field_pkg;

   localparam int FIELD_W    = 2;
   localparam int NUM_FIELDS = 4;
   localparam int WORD_W     = FIELD_W * NUM_FIELDS;
   localparam int SEL_W      = $clog2(NUM_FIELDS);
   localparam int CNT_W      = 8;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

endpackage

// File: rtl/delivery_counter.sv
// Counts delivered words and emits a registered one-cycle pulse on wrap-around.
module delivery_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             ov
);

   logic [CNT_W-1:0] count_r;
   logic             ov_r;

   // Counter and wrap pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
         ov_r    <= 1'b0;
      end else if (en) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         ov_r    <= (count_r == {CNT_W{1'b1}});
      end else begin
         ov_r    <= 1'b0;
      end
   end

   assign count = count_r;
   assign ov    = ov_r;

endmodule

// File: rtl/field_packer.sv
// Collects tagged fields into one word and offers the word on a valid/ready port.
module field_packer
   import field_pkg::*;
#(
   parameter int FIELD_W    = field_pkg::FIELD_W,
   parameter int NUM_FIELDS = field_pkg::NUM_FIELDS
) (
   input  logic                          clk,
   input  logic                          RST,
   input  logic [FIELD_W-1:0]            field,
   input  logic [$clog2(NUM_FIELDS)-1:0] select,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [FIELD_W*NUM_FIELDS-1:0] result,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_FIELDS-1:0]         mask,
   output logic                          dup,
   output logic [CNT_W-1:0]              count,
   output logic                          OV
);

   localparam int WORD_BITS = FIELD_W * NUM_FIELDS;

   state_e                 state_r;
   state_e                 state_nxt_s;
   logic [WORD_BITS-1:0]   result_r;
   logic [WORD_BITS-1:0]   result_nxt_s;
   logic [NUM_FIELDS-1:0]  mask_r;
   logic [NUM_FIELDS-1:0]  mask_nxt_s;
   logic                   dup_r;
   logic                   dup_nxt_s;
   logic                   xfer_s;

   // Slice write decode, completion detect and transfer handling.
   always_comb begin
      state_nxt_s  = state_r;
      result_nxt_s = result_r;
      mask_nxt_s   = mask_r;
      dup_nxt_s    = 1'b0;
      xfer_s       = 1'b0;
      case (state_r)
         COLLECT: begin
            if (in_valid) begin
               result_nxt_s[int'(select)*FIELD_W +: FIELD_W] = field;
               mask_nxt_s[select] = 1'b1;
               dup_nxt_s          = mask_r[select];
               if (&mask_nxt_s) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = COLLECT;
               end
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         HOLD: begin
            // Word is frozen here; only the downstream handshake moves it on.
            if (out_ready) begin
               result_nxt_s = {WORD_BITS{1'b0}};
               mask_nxt_s   = {NUM_FIELDS{1'b0}};
               xfer_s       = 1'b1;
               state_nxt_s  = COLLECT;
            end else begin
               state_nxt_s  = HOLD;
            end
         end
         default: begin
            state_nxt_s = COLLECT;
         end
      endcase
   end

   // State, word, mask and duplicate-pulse registers.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_r  <= COLLECT;
         result_r <= {WORD_BITS{1'b0}};
         mask_r   <= {NUM_FIELDS{1'b0}};
         dup_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         result_r <= result_nxt_s;
         mask_r   <= mask_nxt_s;
         dup_r    <= dup_nxt_s;
      end
   end

   delivery_counter #(
      .CNT_W (CNT_W)
   ) u_delivery_counter (
      .clk   (clk),
      .rst_n (RST),
      .en    (xfer_s),
      .count (count),
      .ov    (OV)
   );

   assign in_ready  = (state_r == COLLECT);
   assign out_valid = (state_r == HOLD);
   assign result    = result_r;
   assign mask      = mask_r;
   assign dup       = dup_r;

endmodule

// File: tb/tb_field_packer.sv
// Self-checking bench for field_packer: vector table, hand sequences and random traffic vs a word-level model.
module tb_field_packer;

   logic       clk = 1'b0;
   logic       RST;
   logic [1:0] field;
   logic [1:0] select;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] result;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] mask;
   logic       dup;
   logic [7:0] count;
   logic       OV;

   int checks = 0;
   int errors = 0;

   // Reference model: which slices hold which value, plus delivery bookkeeping.
   bit m_hold;
   int m_slot[4];
   bit m_wr[4];
   int m_count;
   bit m_dup;
   bit m_ov;

   typedef struct {
      logic       iv;
      logic [1:0] sel;
      logic [1:0] fld;
      logic       ordy;
      logic [7:0] e_result;
      logic [3:0] e_mask;
      logic       e_valid;
      logic       e_dup;
      logic [7:0] e_count;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   field_packer dut (
      .clk       (clk),
      .RST       (RST),
      .field     (field),
      .select    (select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mask      (mask),
      .dup       (dup),
      .count     (count),
      .OV        (OV)
   );

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int exp_result();
      int r = 0;
      for (int i = 0; i < 4; i++) if (m_wr[i]) r += m_slot[i] * (4 ** i);
      return r;
   endfunction

   function automatic int exp_mask();
      int r = 0;
      for (int i = 0; i < 4; i++) if (m_wr[i]) r += (1 << i);
      return r;
   endfunction

   task automatic model_reset();
      m_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_slot[i] = 0;
         m_wr[i]   = 1'b0;
      end
      m_count = 0;
      m_dup   = 1'b0;
      m_ov    = 1'b0;
   endtask

   task automatic model_edge(input logic iv, input int sel, input int fld, input logic ordy);
      bit full;
      m_dup = 1'b0;
      m_ov  = 1'b0;
      if (!m_hold) begin
         if (iv) begin
            if (m_wr[sel]) m_dup = 1'b1;
            m_slot[sel] = fld;
            m_wr[sel]   = 1'b1;
            full = 1'b1;
            for (int i = 0; i < 4; i++) full &= m_wr[i];
            m_hold = full;
         end
      end else if (ordy) begin
         for (int i = 0; i < 4; i++) begin
            m_slot[i] = 0;
            m_wr[i]   = 1'b0;
         end
         m_ov    = (m_count == 255);
         m_count = (m_count + 1) % 256;
         m_hold  = 1'b0;
      end
   endtask

   task automatic check_model();
      check_eq("result",    result,    exp_result());
      check_eq("mask",      mask,      exp_mask());
      check_eq("out_valid", out_valid, m_hold);
      check_eq("in_ready",  in_ready,  !m_hold);
      check_eq("dup",       dup,       m_dup);
      check_eq("count",     count,     m_count);
      check_eq("OV",        OV,        m_ov);
   endtask

   task automatic cycle(input logic iv, input logic [1:0] sel, input logic [1:0] fld, input logic ordy);
      in_valid  = iv;
      select    = sel;
      field     = fld;
      out_ready = ordy;
      @(posedge clk);
      model_edge(iv, int'(sel), int'(fld), ordy);
      #1;
      check_model();
   endtask

   task automatic async_reset(input string name);
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      check_eq({name, ".result"},    result,    8'h00);
      check_eq({name, ".mask"},      mask,      4'h0);
      check_eq({name, ".count"},     count,     8'h00);
      check_eq({name, ".out_valid"}, out_valid, 1'b0);
      check_eq({name, ".in_ready"},  in_ready,  1'b1);
      check_eq({name, ".dup"},       dup,       1'b0);
      check_eq({name, ".OV"},        OV,        1'b0);
      #3;
      RST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   ov_pulses;
      logic [7:0] held;

      vecs[0]  = '{1'b1, 2'd0, 2'b01, 1'b1, 8'h01, 4'h1, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 2'd1, 2'b10, 1'b1, 8'h09, 4'h3, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 2'd2, 2'b11, 1'b1, 8'h39, 4'h7, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1'b1, 2'd3, 2'b00, 1'b1, 8'h39, 4'hF, 1'b1, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 2'd0, 2'b00, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'd1};
      vecs[5]  = '{1'b1, 2'd3, 2'd3,  1'b0, 8'hC0, 4'h8, 1'b0, 1'b0, 8'd1};
      vecs[6]  = '{1'b1, 2'd1, 2'd1,  1'b0, 8'hC4, 4'hA, 1'b0, 1'b0, 8'd1};
      vecs[7]  = '{1'b1, 2'd1, 2'd2,  1'b0, 8'hC8, 4'hA, 1'b0, 1'b1, 8'd1};
      vecs[8]  = '{1'b1, 2'd0, 2'd0,  1'b0, 8'hC8, 4'hB, 1'b0, 1'b0, 8'd1};
      vecs[9]  = '{1'b1, 2'd2, 2'd1,  1'b0, 8'hD8, 4'hF, 1'b1, 1'b0, 8'd1};
      vecs[10] = '{1'b0, 2'd0, 2'd0,  1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 8'd2};

      RST       = 1'b0;
      field     = 2'd0;
      select    = 2'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_reset();
      #12;
      check_model();
      check_eq("reset.in_ready", in_ready, 1'b1);
      #5;
      RST = 1'b1;

      // In-order fill and out-of-order fill with a duplicate slice.
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].iv, vecs[i].sel, vecs[i].fld, vecs[i].ordy);
         check_eq($sformatf("vec%0d.result", i),    result,    vecs[i].e_result);
         check_eq($sformatf("vec%0d.mask", i),      mask,      vecs[i].e_mask);
         check_eq($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].e_valid);
         check_eq($sformatf("vec%0d.dup", i),       dup,       vecs[i].e_dup);
         check_eq($sformatf("vec%0d.count", i),     count,     vecs[i].e_count);
      end

      // Backpressure: inputs offered while the word is held must be ignored.
      for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 2'($urandom_range(0, 3)), 1'b0);
      held = 8'(exp_result());
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
         check_eq("bp.in_ready", in_ready, 1'b0);
         check_eq("bp.result",   result,   held);
         check_eq("bp.mask",     mask,     4'hF);
      end
      cycle(1'b0, 2'd0, 2'd0, 1'b1);
      check_eq("bp.count", count, 8'd3);
      cycle(1'b0, 2'd0, 2'd0, 1'b1);
      check_eq("bp.single_xfer", count, 8'd3);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Async reset mid-word and mid-HOLD.
      cycle(1'b1, 2'd0, 2'($urandom_range(0, 3)), 1'b0);
      cycle(1'b1, 2'd1, 2'($urandom_range(0, 3)), 1'b0);
      async_reset("rst_partial");
      for (int s = 0; s < 4; s++) cycle(1'b1, 2'(3 - s), 2'($urandom_range(0, 3)), 1'b0);
      cycle(1'b0, 2'd0, 2'd0, 1'b0);
      async_reset("rst_hold");
      for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 2'd2, 1'b1);
      check_eq("post_rst.result", result, 8'hAA);
      cycle(1'b0, 2'd0, 2'd0, 1'b1);
      check_eq("post_rst.count", count, 8'd1);

      // Counter wrap: 256 deliveries from zero.
      async_reset("rst_wrap");
      ov_pulses = 0;
      for (int w = 1; w <= 256; w++) begin
         for (int s = 0; s < 4; s++) cycle(1'b1, 2'(s), 2'($urandom_range(0, 3)), 1'b0);
         cycle(1'b0, 2'd0, 2'd0, 1'b1);
         if (OV === 1'b1) ov_pulses++;
         if (w == 255 || w == 256) check_eq($sformatf("wrap.ov_w%0d", w), OV, (w == 256));
      end
      cycle(1'b0, 2'd0, 2'd0, 1'b0);
      if (OV === 1'b1) ov_pulses++;
      check_eq("wrap.count",     count,     8'h00);
      check_eq("wrap.ov_pulses", ov_pulses, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/field_packer.md
# field_packer

Write-side counterpart of the `case_no_full` field selector. It accepts 2-bit fields tagged with a 2-bit `select` index and deposits each one into the matching slice of an 8-bit word. Once all four slices have been written, it presents the assembled byte on a valid/ready output port. It also counts delivered bytes and flags counter wrap-around, the same way the team's counters report `OV`.

## Interface
- `FIELD_W`, default 2: width of one field.
- `NUM_FIELDS`, default 4: fields per word. Word width is `FIELD_W*NUM_FIELDS` = 8; select width is clog2(`NUM_FIELDS`) = 2.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `field`  in  2  field data.
- `select`  in  2  target slice; slice i occupies bits [2i+1:2i].
- `in_valid`  in  1  `field`/`select` are valid this cycle.
- `in_ready`  out  1  the block can accept a field this cycle.
- `result`  out  8  assembled word register.
- `out_valid`  out  1  `result` is complete and offered downstream.
- `out_ready`  in  1  downstream accepts `result`.
- `mask`  out  4  bit i is set when slice i has been written in the current word.
- `dup`  out  1  one-cycle pulse: a slice was rewritten before the word completed.
- `count`  out  8  number of words delivered, modulo 256.
- `OV`  out  1  one-cycle pulse when `count` wraps from 0xFF to 0x00.

## Operation
- Two states:
  - COLLECT: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- `in_ready` and `out_valid` are decoded directly from the state register.
- Accept in COLLECT (`in_valid`=1):
  - `result[2*select +: 2]` <= `field`.
  - `mask[select]` <= 1.
  - If `mask[select]` was already 1, the slice is overwritten (last write wins) and `dup` pulses in the next cycle.
- Completion: when the updated mask equals 4'b1111, the next state is HOLD.
  - Slices may arrive in any order.
  - A slice written twice still counts once.
- HOLD:
  - `in_valid` is ignored. No field is captured and `dup` stays 0.
  - `result` and `mask` are frozen.
- Transfer (HOLD and `out_ready`=1):
  - `result` <= 0, `mask` <= 0, `count` <= `count`+1.
  - Next state is COLLECT.
  - If `count` was 0xFF, it becomes 0x00 and `OV` pulses for one cycle.
- `out_ready` has no effect in COLLECT.
- `result` is always visible. Slices whose `mask` bit is 0 read as 0.

## Timing
- Reset (`RST`=0, asynchronous):
  - State goes to COLLECT.
  - `result`=0, `mask`=0, `count`=0, `dup`=0, `OV`=0, `out_valid`=0, `in_ready`=1.
- Reset mid-word or mid-HOLD discards the partial or pending word without delivering it and without incrementing `count`.
- Latency: final slice accepted at edge k → `out_valid`=1 from edge k through the transfer edge.
- Back-to-back:
  - Transfer at edge t → `in_ready`=1 after t, so the first field of the next word can be accepted at edge t+1.
  - Peak throughput is one word per 5 cycles.
- `out_valid` stays high and `result` stays stable until the transfer occurs. There is no timeout.
- `dup` and `OV` are registered and asserted for exactly one cycle after the causing edge.

## Structure
- Shared package `field_pkg` holds:
  - `FIELD_W`, `NUM_FIELDS`, derived word and select widths.
  - State encoding: COLLECT=1'b0, HOLD=1'b1.
- One sub-module, `delivery_counter`:
  - 8-bit enable counter with async active-low reset.
  - Registered wrap pulse `OV`.
  - Increment enable = transfer.
- Everything else (slice write decode, mask, FSM) lives in `field_packer`.

## Test plan
- **In-order fill:** fields 2'b01, 2'b10, 2'b11, 2'b00 at `select` 0..3 on consecutive cycles with `out_ready`=1 → `result`=8'h39 and `out_valid`=1 for exactly one cycle, then `count`=1, `mask`=0, `result`=0.
- **Out-of-order with duplicate:** `select` 3,1,1,0,2 with fields 3,1,2,0,1 → `dup` pulses once after the second slice-1 write, then `result`=8'hD8.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with `in_valid`=1 and random data → `in_ready`=0, `result` unchanged, `mask`=4'hF. Raise `out_ready` → single transfer.
- **Counter wrap:** deliver 256 words → `count` returns to 0x00 and `OV` pulses exactly once, on the 256th transfer.
- **Async reset:** assert `RST`=0 between edges after 2 slices, and again during HOLD → all outputs at reset values immediately. After release, a full fill delivers normally and `count` is not incremented by the aborted words.
